// File: rtl/de_pipe_reg_pkg.sv
// Shared D/E pipeline definitions: datapath widths, reset PC, NOP word and Tnew encoding.
// Also imported by the F/D register and the hazard unit.
package de_pipe_reg_pkg;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned TW    = 2;
    localparam int unsigned CNT_W = 16;

    localparam logic [DW-1:0] PC_RESET = 32'h0000_3000;
    localparam logic [DW-1:0] NOP_WORD = 32'h0000_0000;

    typedef logic [DW-1:0]    word_t;
    typedef logic [AW-1:0]    gpr_addr_t;
    typedef logic [TW-1:0]    tnew_t;
    typedef logic [CNT_W-1:0] bubble_cnt_t;

    // Tnew 0 means the result is already available; nothing younger can need it sooner
    localparam tnew_t       TNEW_READY = '0;
    localparam gpr_addr_t   WA_NONE    = '0;
    localparam bubble_cnt_t CNT_MAX    = '1;

    // Decrement of Tnew when the instruction advances one stage; floors at TNEW_READY
    function automatic tnew_t tnew_sat_dec(input tnew_t t);
        return (t == TNEW_READY) ? TNEW_READY : tnew_t'(t - TW'(1));
    endfunction

endpackage

// File: rtl/de_pipe_reg_if.sv
// D->E stage bus: D-stage payload and control in, registered E-stage payload out.
interface de_pipe_reg_if import de_pipe_reg_pkg::*; ();

    logic        stall;
    logic        flush;

    word_t       D_pc;
    word_t       D_instr;
    word_t       D_rs_data;
    word_t       D_rt_data;
    word_t       D_imm32;
    gpr_addr_t   D_wa;
    tnew_t       D_tnew;

    word_t       E_pc;
    word_t       E_instr;
    word_t       E_rs_data;
    word_t       E_rt_data;
    word_t       E_imm32;
    gpr_addr_t   E_wa;
    tnew_t       E_tnew;
    logic        E_valid;
    bubble_cnt_t bubble_cnt;

    // Decode side / hazard unit drives the D payload and controls
    modport master (
        output stall, flush,
        output D_pc, D_instr, D_rs_data, D_rt_data, D_imm32, D_wa, D_tnew,
        input  E_pc, E_instr, E_rs_data, E_rt_data, E_imm32, E_wa, E_tnew, E_valid,
        input  bubble_cnt
    );

    // The pipeline register itself
    modport slave (
        input  stall, flush,
        input  D_pc, D_instr, D_rs_data, D_rt_data, D_imm32, D_wa, D_tnew,
        output E_pc, E_instr, E_rs_data, E_rt_data, E_imm32, E_wa, E_tnew, E_valid,
        output bubble_cnt
    );

endinterface

// File: rtl/de_pipe_reg_pipe_field.sv
// One pipeline-register field: async reset value, clear-to-value has priority over load.
module de_pipe_reg_pipe_field #(
    parameter int unsigned    W       = 32,
    parameter logic [W-1:0]   RST_VAL = '0,
    parameter logic [W-1:0]   CLR_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] field_q;
    logic [W-1:0] field_d;

    always_comb begin
        field_d = field_q;
        if (clr_i) begin
            field_d = CLR_VAL;
        end else if (ld_i) begin
            field_d = d_i;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            field_q <= RST_VAL;
        end else begin
            field_q <= field_d;
        end
    end

    assign q_o = field_q;

endmodule

// File: rtl/de_pipe_reg.sv
// D->E pipeline register: loads the decoded instruction into E, or inserts a bubble on
// stall/flush, and keeps a saturating count of inserted bubbles.
module de_pipe_reg import de_pipe_reg_pkg::*; (
    input  logic          clk,
    input  logic          reset,
    de_pipe_reg_if.slave  de_if
);

    logic        bubble_c;
    logic        load_c;
    logic        pc_ld_c;
    tnew_t       tnew_dec_c;
    bubble_cnt_t bubble_cnt_q;
    bubble_cnt_t bubble_cnt_d;

    // Flush wins over stall; a stalled slot still carries D's PC for traceability
    assign bubble_c   = de_if.stall | de_if.flush;
    assign load_c     = ~bubble_c;
    assign pc_ld_c    = ~de_if.flush;
    assign tnew_dec_c = tnew_sat_dec(de_if.D_tnew);

    de_pipe_reg_pipe_field #(.W(DW), .RST_VAL(PC_RESET), .CLR_VAL(PC_RESET)) u_pc (
        .clk   (clk),
        .reset (reset),
        .ld_i  (pc_ld_c),
        .clr_i (de_if.flush),
        .d_i   (de_if.D_pc),
        .q_o   (de_if.E_pc)
    );

    de_pipe_reg_pipe_field #(.W(DW), .RST_VAL(NOP_WORD), .CLR_VAL(NOP_WORD)) u_instr (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (de_if.D_instr),
        .q_o   (de_if.E_instr)
    );

    de_pipe_reg_pipe_field #(.W(DW), .RST_VAL('0), .CLR_VAL('0)) u_rs (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (de_if.D_rs_data),
        .q_o   (de_if.E_rs_data)
    );

    de_pipe_reg_pipe_field #(.W(DW), .RST_VAL('0), .CLR_VAL('0)) u_rt (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (de_if.D_rt_data),
        .q_o   (de_if.E_rt_data)
    );

    de_pipe_reg_pipe_field #(.W(DW), .RST_VAL('0), .CLR_VAL('0)) u_imm (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (de_if.D_imm32),
        .q_o   (de_if.E_imm32)
    );

    de_pipe_reg_pipe_field #(.W(AW), .RST_VAL(WA_NONE), .CLR_VAL(WA_NONE)) u_wa (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (de_if.D_wa),
        .q_o   (de_if.E_wa)
    );

    de_pipe_reg_pipe_field #(.W(TW), .RST_VAL(TNEW_READY), .CLR_VAL(TNEW_READY)) u_tnew (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (tnew_dec_c),
        .q_o   (de_if.E_tnew)
    );

    de_pipe_reg_pipe_field #(.W(1), .RST_VAL(1'b0), .CLR_VAL(1'b0)) u_valid (
        .clk   (clk),
        .reset (reset),
        .ld_i  (load_c),
        .clr_i (bubble_c),
        .d_i   (1'b1),
        .q_o   (de_if.E_valid)
    );

    // Perf-debug bubble counter, sticks at all-ones
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (bubble_c && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign de_if.bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Self-checking bench for de_pipe_reg: directed cases plus randomized traffic against
// a behavioural model of the D->E register.
module tb_de_pipe_reg;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    de_pipe_reg_if bus ();

    de_pipe_reg dut (
        .clk   (clk),
        .reset (reset),
        .de_if (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model of E-stage contents
    logic [31:0] m_pc, m_instr, m_rs, m_rt, m_imm;
    logic [4:0]  m_wa;
    logic [1:0]  m_tnew;
    logic        m_valid;
    int          m_cnt;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_pc = 32'h3000; m_instr = '0; m_rs = '0; m_rt = '0; m_imm = '0;
            m_wa = '0; m_tnew = '0; m_valid = 1'b0; m_cnt = 0;
        end else if (bus.stall || bus.flush) begin
            m_pc    = bus.flush ? 32'h3000 : bus.D_pc;
            m_instr = '0; m_rs = '0; m_rt = '0; m_imm = '0;
            m_wa    = '0; m_tnew = '0; m_valid = 1'b0;
            if (m_cnt < 65535) m_cnt = m_cnt + 1;
        end else begin
            m_pc    = bus.D_pc;      m_instr = bus.D_instr;
            m_rs    = bus.D_rs_data; m_rt    = bus.D_rt_data;
            m_imm   = bus.D_imm32;   m_wa    = bus.D_wa;
            m_tnew  = (int'(bus.D_tnew) == 0) ? 2'd0 : 2'(int'(bus.D_tnew) - 1);
            m_valid = 1'b1;
        end
    end

    // Per-cycle compare of every E output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if ({bus.E_pc, bus.E_instr, bus.E_rs_data, bus.E_rt_data, bus.E_imm32,
                 bus.E_wa, bus.E_tnew, bus.E_valid, bus.bubble_cnt} ===
                {m_pc, m_instr, m_rs, m_rt, m_imm, m_wa, m_tnew, m_valid, 16'(m_cnt)}) begin
                n_pass++;
            end else begin
                $display("FAIL model_cycle t=%0t got pc=%h ins=%h rs=%h rt=%h imm=%h wa=%0d tn=%0d v=%b cnt=%h exp pc=%h ins=%h rs=%h rt=%h imm=%h wa=%0d tn=%0d v=%b cnt=%h",
                         $time, bus.E_pc, bus.E_instr, bus.E_rs_data, bus.E_rt_data, bus.E_imm32,
                         bus.E_wa, bus.E_tnew, bus.E_valid, bus.bubble_cnt,
                         m_pc, m_instr, m_rs, m_rt, m_imm, m_wa, m_tnew, m_valid, 16'(m_cnt));
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rand();
        bus.D_pc      = $urandom;
        bus.D_instr   = $urandom;
        bus.D_rs_data = $urandom;
        bus.D_rt_data = $urandom;
        bus.D_imm32   = $urandom;
        bus.D_wa      = 5'($urandom_range(0, 31));
        bus.D_tnew    = 2'($urandom_range(0, 3));
    endtask

    logic [31:0] held_instr;

    initial begin
        bus.stall = 1'b0; bus.flush = 1'b0;
        bus.D_pc = '0; bus.D_instr = '0; bus.D_rs_data = '0; bus.D_rt_data = '0;
        bus.D_imm32 = '0; bus.D_wa = '0; bus.D_tnew = '0;
        tick(); tick();
        reset = 1'b0;
        chk_en = 1'b1;
        chk("rst_pc",    64'(bus.E_pc),       64'h3000);
        chk("rst_valid", 64'(bus.E_valid),    64'h0);
        chk("rst_cnt",   64'(bus.bubble_cnt), 64'h0);

        // Load with Tnew decrement
        drive_rand();
        bus.D_pc = 32'h3004; bus.D_imm32 = 32'hFFFF_FFF0; bus.D_tnew = 2'd2; bus.D_wa = 5'd5;
        tick();
        chk("load_imm",   64'(bus.E_imm32), 64'hFFFF_FFF0);
        chk("load_tnew",  64'(bus.E_tnew),  64'h1);
        chk("load_wa",    64'(bus.E_wa),    64'h5);
        chk("load_valid", 64'(bus.E_valid), 64'h1);
        chk("load_pc",    64'(bus.E_pc),    64'h3004);

        bus.D_tnew = 2'd0;
        tick();
        chk("tnew_floor", 64'(bus.E_tnew), 64'h0);

        // Async reset between edges while E holds a real instruction
        #2 reset = 1'b1;
        #1;
        chk("arst_pc",    64'(bus.E_pc),       64'h3000);
        chk("arst_valid", 64'(bus.E_valid),    64'h0);
        chk("arst_instr", 64'(bus.E_instr),    64'h0);
        chk("arst_cnt",   64'(bus.bubble_cnt), 64'h0);
        tick();
        reset = 1'b0;

        // Three stall cycles, then re-issue
        drive_rand();
        bus.D_pc = 32'h3008;
        held_instr = bus.D_instr;
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_instr", 64'(bus.E_instr), 64'h0);
            chk("stall_valid", 64'(bus.E_valid), 64'h0);
            chk("stall_pc",    64'(bus.E_pc),    64'h3008);
        end
        chk("stall_cnt", 64'(bus.bubble_cnt), 64'h3);
        bus.stall = 1'b0;
        tick();
        chk("reissue_valid", 64'(bus.E_valid), 64'h1);
        chk("reissue_instr", 64'(bus.E_instr), 64'(held_instr));
        chk("reissue_pc",    64'(bus.E_pc),    64'h3008);

        // Stall and flush together count as one flush
        bus.stall = 1'b1; bus.flush = 1'b1;
        tick();
        chk("sf_pc",    64'(bus.E_pc),       64'h3000);
        chk("sf_valid", 64'(bus.E_valid),    64'h0);
        chk("sf_cnt",   64'(bus.bubble_cnt), 64'h4);

        // Randomized traffic with occasional async resets
        for (int i = 0; i < 2000; i++) begin
            drive_rand();
            bus.stall = ($urandom_range(0, 3) == 0);
            bus.flush = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 199) == 0);
            tick();
        end
        reset = 1'b0;

        // Saturation of the bubble counter
        #2 reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.stall = 1'b1; bus.flush = 1'b0;
        for (int i = 0; i < 65534; i++) begin
            drive_rand();
            tick();
        end
        chk("cnt_fffe", 64'(bus.bubble_cnt), 64'hFFFE);
        tick();
        chk("cnt_ffff", 64'(bus.bubble_cnt), 64'hFFFF);
        tick();
        chk("cnt_hold", 64'(bus.bubble_cnt), 64'hFFFF);
        bus.flush = 1'b1;
        tick();
        chk("cnt_hold2", 64'(bus.bubble_cnt), 64'hFFFF);

        bus.stall = 1'b0; bus.flush = 1'b0;
        tick();
        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
